// File: rtl/settings_pkg.sv
// rtl/settings_pkg.sv - shared sizing constants and types for the convolution datapath
package settings_pkg;

    // Width of the raw convolution accumulator result
    localparam int FULL_SIZE    = 40;
    // Width of the shaped output sample
    localparam int DATA_SIZE    = 16;
    // Result shaper: right shift applied before rounding, and output FIFO depth
    localparam int SHAPER_SHIFT = 8;
    localparam int SHAPER_DEPTH = 8;

    // Saturating statistics counter
    typedef logic [15:0] stat_count_t;

endpackage

// File: rtl/convol_result_intf.sv
// rtl/convol_result_intf.sv - convolution result bundle from the accumulator stage to the shaper
interface convol_result_intf #(
    parameter int FULL_SIZE = settings_pkg::FULL_SIZE
) ();

    logic signed [FULL_SIZE-1:0] output_data;
    logic                        output_data_valid;

    modport master (output output_data, output output_data_valid);
    modport slave  (input  output_data, input  output_data_valid);

endinterface

// File: rtl/convol_sync_fifo.sv
// rtl/convol_sync_fifo.sv - single-clock show-ahead FIFO with occupancy level
module convol_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Gate requests by occupancy; a pop frees the slot for a same-cycle push when full
    always_comb begin
        full     = (count_q == (AW+1)'(DEPTH));
        empty    = (count_q == '0);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, intentionally left out of reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign level   = count_q;

endmodule

// File: rtl/convol_result_shaper.sv
// rtl/convol_result_shaper.sv - round/saturate convolution results into an output FIFO; CONVOL_SHAPER_STATS_EN enables counters
module convol_result_shaper #(
    parameter int FULL_SIZE = settings_pkg::FULL_SIZE,
    parameter int DATA_SIZE = settings_pkg::DATA_SIZE,
    parameter int SHIFT     = settings_pkg::SHAPER_SHIFT,
    parameter int DEPTH     = settings_pkg::SHAPER_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [FULL_SIZE-1:0]  output_data,
    input  logic                         output_data_valid,
    output logic signed [DATA_SIZE-1:0]  out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         sat_flag,
    output logic                         overflow,
    input  logic                         clear_flags,
    output settings_pkg::stat_count_t    drop_count,
    output settings_pkg::stat_count_t    sat_count
);

    localparam logic signed [FULL_SIZE:0] ROUND_BIAS = {{FULL_SIZE{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [FULL_SIZE:0] SAT_MAX    = {{(FULL_SIZE-DATA_SIZE+2){1'b0}}, {(DATA_SIZE-1){1'b1}}};
    localparam logic signed [FULL_SIZE:0] SAT_MIN    = {{(FULL_SIZE-DATA_SIZE+2){1'b1}}, {(DATA_SIZE-1){1'b0}}};

    logic signed [FULL_SIZE:0]   rounded_sum;
    logic signed [FULL_SIZE:0]   shifted;
    logic                        sat_hi, sat_lo, saturated;
    logic [DATA_SIZE-1:0]        sat_value;

    logic [DATA_SIZE-1:0]        s1_data_q, s1_data_d;
    logic                        s1_valid_q, s1_valid_d;
    logic                        sat_flag_q, sat_flag_d;
    logic                        overflow_q, overflow_d;

    logic                        fifo_full, fifo_empty;
    logic                        pop, drop;
    logic [DATA_SIZE-1:0]        fifo_rd_data;

    // Round half-up at one extra bit so the bias cannot overflow, then clamp to the output range
    always_comb begin
        rounded_sum = $signed({output_data[FULL_SIZE-1], output_data}) + ROUND_BIAS;
        shifted     = rounded_sum >>> SHIFT;
        sat_hi      = (shifted > SAT_MAX);
        sat_lo      = (shifted < SAT_MIN);
        saturated   = sat_hi || sat_lo;
        if (sat_hi) begin
            sat_value = SAT_MAX[DATA_SIZE-1:0];
        end else if (sat_lo) begin
            sat_value = SAT_MIN[DATA_SIZE-1:0];
        end else begin
            sat_value = shifted[DATA_SIZE-1:0];
        end
    end

    // Stage-1 capture, FIFO handshake and sticky flags; clear wins over a same-cycle set
    always_comb begin
        s1_valid_d = output_data_valid;
        s1_data_d  = output_data_valid ? sat_value : s1_data_q;
        pop        = out_valid && out_ready;
        drop       = s1_valid_q && fifo_full && !pop;
        if (clear_flags) begin
            sat_flag_d = 1'b0;
            overflow_d = 1'b0;
        end else begin
            sat_flag_d = sat_flag_q || (output_data_valid && saturated);
            overflow_d = overflow_q || drop;
        end
    end

    // Stage-1 register and sticky flag state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
            sat_flag_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            s1_data_q  <= s1_data_d;
            s1_valid_q <= s1_valid_d;
            sat_flag_q <= sat_flag_d;
            overflow_q <= overflow_d;
        end
    end

    convol_sync_fifo #(
        .WIDTH (DATA_SIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (s1_valid_q),
        .wr_data (s1_data_q),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_rd_data;
    assign sat_flag  = sat_flag_q;
    assign overflow  = overflow_q;

`ifdef CONVOL_SHAPER_STATS_EN
    settings_pkg::stat_count_t drop_count_q, drop_count_d;
    settings_pkg::stat_count_t sat_count_q, sat_count_d;

    // Saturating event counters; they stick at all-ones instead of wrapping
    always_comb begin
        drop_count_d = drop_count_q;
        sat_count_d  = sat_count_q;
        if (clear_flags) begin
            drop_count_d = '0;
            sat_count_d  = '0;
        end else begin
            if (drop && (drop_count_q != '1)) begin
                drop_count_d = drop_count_q + 16'd1;
            end
            if (output_data_valid && saturated && (sat_count_q != '1)) begin
                sat_count_d = sat_count_q + 16'd1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_count_q <= '0;
            sat_count_q  <= '0;
        end else begin
            drop_count_q <= drop_count_d;
            sat_count_q  <= sat_count_d;
        end
    end

    assign drop_count = drop_count_q;
    assign sat_count  = sat_count_q;
`else
    assign drop_count = '0;
    assign sat_count  = '0;
`endif

endmodule

// File: tb/tb_convol_result_shaper.sv
// tb/tb_convol_result_shaper.sv - directed self-checking bench for convol_result_shaper
module tb_convol_result_shaper;

    localparam int FULL_SIZE = 40;
    localparam int DATA_SIZE = 16;
    localparam int DEPTH     = 8;
`ifdef CONVOL_SHAPER_STATS_EN
    localparam longint STATS = 1;
`else
    localparam longint STATS = 0;
`endif

    logic                        clk;
    logic                        reset;
    logic signed [FULL_SIZE-1:0] output_data;
    logic                        output_data_valid;
    logic signed [DATA_SIZE-1:0] out_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [$clog2(DEPTH):0]      level;
    logic                        sat_flag;
    logic                        overflow;
    logic                        clear_flags;
    logic [15:0]                 drop_count;
    logic [15:0]                 sat_count;

    int checks   = 0;
    int failures = 0;

    convol_result_shaper #(
        .FULL_SIZE (FULL_SIZE),
        .DATA_SIZE (DATA_SIZE),
        .SHIFT     (8),
        .DEPTH     (DEPTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .output_data       (output_data),
        .output_data_valid (output_data_valid),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .level             (level),
        .sat_flag          (sat_flag),
        .overflow          (overflow),
        .clear_flags       (clear_flags),
        .drop_count        (drop_count),
        .sat_count         (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input longint v);
        output_data       = FULL_SIZE'(v);
        output_data_valid = 1'b1;
        tick();
        output_data_valid = 1'b0;
    endtask

    // One isolated sample through an empty FIFO with out_ready high
    task automatic single(input string tag, input longint v, input longint exp);
        send(v);
        check({tag, "_valid_e1"}, out_valid, 0);
        tick();
        check({tag, "_valid_e2"}, out_valid, 1);
        check({tag, "_data"}, out_data, exp);
        tick();
        check({tag, "_valid_e3"}, out_valid, 0);
    endtask

    initial begin
        reset             = 1'b0;
        output_data       = '0;
        output_data_valid = 1'b0;
        out_ready         = 1'b0;
        clear_flags       = 1'b0;
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_level", level, 0);
        check("rst_sat_flag", sat_flag, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_sat_count", sat_count, 0);
        reset = 1'b1;
        out_ready = 1'b1;

        // Rounding, latency and single-cycle presence
        single("pos384", 384, 2);
        single("neg384", -384, -1);
        single("pos128", 128, 1);
        single("pos127", 127, 0);
        single("neg129", -129, -1);
        single("neg128", -128, 0);
        check("no_sat_flag", sat_flag, 0);

        // Saturation at both rails
        single("sat_hi", longint'(1) << 30, 32767);
        check("sat_hi_flag", sat_flag, 1);
        check("sat_hi_count", sat_count, STATS * 1);
        single("sat_lo", -(longint'(1) << 30), -32768);
        check("sat_lo_count", sat_count, STATS * 2);
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        check("clr_sat_flag", sat_flag, 0);
        check("clr_sat_count", sat_count, 0);

        // Overflow: ten samples into an eight-entry FIFO with no consumer
        out_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            output_data       = FULL_SIZE'(256 * k);
            output_data_valid = 1'b1;
            tick();
        end
        output_data_valid = 1'b0;
        tick();
        check("ovf_level", level, 8);
        check("ovf_flag", overflow, 1);
        check("ovf_drop_count", drop_count, STATS * 2);
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("ovf_pop%0d", k), out_data, k);
            tick();
        end
        check("ovf_drained_valid", out_valid, 0);
        check("ovf_drained_level", level, 0);

        // Full FIFO with concurrent push and pop keeps level and order
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        out_ready = 1'b0;
        for (int k = 11; k <= 19; k++) begin
            output_data       = FULL_SIZE'(256 * k);
            output_data_valid = 1'b1;
            tick();
        end
        check("full_level", level, 8);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            output_data       = FULL_SIZE'(256 * (20 + i));
            output_data_valid = 1'b1;
            check($sformatf("full_level_%0d", i), level, 8);
            check($sformatf("full_data_%0d", i), out_data, 11 + i);
            tick();
        end
        output_data_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check($sformatf("full_drain_%0d", i), out_data, 19 + i);
            tick();
        end
        check("full_end_level", level, 0);
        check("full_no_overflow", overflow, 0);
        check("full_no_drops", drop_count, 0);

        // Asynchronous reset mid-burst
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            send(256 * k);
        end
        tick();
        check("pre_rst_level", level, 5);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_level", level, 0);
        tick();
        reset = 1'b1;
        out_ready = 1'b1;
        single("post_rst", 256 * 7, 7);
        check("post_rst_level", level, 0);

        // Clear wins over a same-cycle drop
        out_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            output_data       = FULL_SIZE'(256 * k);
            output_data_valid = 1'b1;
            tick();
        end
        output_data_valid = 1'b0;
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        check("clr_drop_level", level, 8);
        check("clr_drop_overflow", overflow, 0);
        check("clr_drop_count", drop_count, 0);
        send(256 * 10);
        tick();
        check("drop_after_clr_overflow", overflow, 1);
        check("drop_after_clr_count", drop_count, STATS * 1);
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("clr_pop%0d", k), out_data, k);
            tick();
        end
        check("final_level", level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/convol_result_shaper.md
CONVOL_RESULT_SHAPER -- requirements
Module: convol_result_shaper

Interface
REQ-001 SHALL have parameter FULL_SIZE, default FULL_SIZE from settings_pkg: width of the incoming convolution result.
REQ-002 SHALL have parameter DATA_SIZE, default DATA_SIZE from settings_pkg: width of the shaped output sample.
REQ-003 SHALL have parameter SHIFT, default 8: right-shift applied before rounding; legal range 1..FULL_SIZE-DATA_SIZE.
REQ-004 SHALL have parameter DEPTH, default 8: FIFO entries; power of two, ≥2.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is clocked on its rising edge.
REQ-006 SHALL have port reset, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port output_data, input, FULL_SIZE signed: convolution result from the upstream stage.
REQ-008 SHALL have port output_data_valid, input, 1: marks output_data as valid; there is no backpressure to upstream.
REQ-009 SHALL have port out_data, output, DATA_SIZE signed: shaped sample at the FIFO head.
REQ-010 SHALL have port out_valid, output, 1: FIFO non-empty.
REQ-011 SHALL have port out_ready, input, 1: the consumer accepts the sample; a pop occurs when out_valid && out_ready.
REQ-012 SHALL have port level, output, $clog2(DEPTH)+1: FIFO occupancy.
REQ-013 SHALL have port sat_flag, output, 1: sticky saturation flag.
REQ-014 SHALL have port overflow, output, 1: sticky drop flag.
REQ-015 SHALL have port clear_flags, input, 1: synchronous clear of the sticky flags and counters.
REQ-016 SHALL have ports drop_count and sat_count, output, 16 each: statistics counters (see Configuration).

Function
REQ-017 SHALL compute the stage-1 value as (output_data + 2^(SHIFT-1)) >>> SHIFT: round-half-up, arithmetic shift, with the add performed at FULL_SIZE+1 bits.
REQ-018 SHALL saturate the stage-1 value to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1] and register it, together with a valid bit, on the edge that samples output_data_valid.
REQ-019 SHALL set sat_flag on the edge that registers a saturated valid sample.
REQ-020 SHALL write the stage-1 register into the FIFO on the next edge, provided its valid bit is high and the FIFO is not full, or a pop occurs in the same cycle.
REQ-021 SHALL, when full with no concurrent pop, drop the sample, set overflow and increment drop_count; FIFO contents stay unchanged.
REQ-022 SHALL, on a simultaneous push and pop, leave level unchanged and preserve data order, including when empty-to-empty is not possible and when the FIFO is full.
REQ-023 SHALL present out_data combinationally from mem[rd_ptr] (show-ahead); out_data is don't-care while out_valid is 0.
REQ-024 SHALL have a latency of exactly 2 edges from a sampled output_data_valid to out_valid when the FIFO was empty.
REQ-025 SHALL wrap the read/write pointers modulo DEPTH; level SHALL never exceed DEPTH.
REQ-026 SHALL saturate drop_count and sat_count at 16'hFFFF rather than wrap.
REQ-027 SHALL give clear_flags priority over a same-cycle set/increment, leaving the flags and counters 0 after that edge.

Reset
REQ-028 SHALL, on assertion of reset (low), immediately drive out_valid=0, level=0, sat_flag=0, overflow=0, drop_count=0, sat_count=0, clear the pointers and the stage-1 valid bit, and lose any in-flight sample.
REQ-029 SHALL leave the FIFO memory contents unreset.
REQ-030 SHALL ignore inputs until the first clock edge after reset deassertion.

Configuration
REQ-031 SHALL, with CONVOL_SHAPER_STATS_EN defined, implement drop_count and sat_count as specified.
REQ-032 SHALL, without CONVOL_SHAPER_STATS_EN, keep the ports but tie drop_count and sat_count to 0; the flags remain functional.

Structure
REQ-033 SHALL take FULL_SIZE and DATA_SIZE from settings_pkg and add SHAPER_SHIFT, SHAPER_DEPTH and a stat_count_t (16-bit) typedef there.
REQ-034 SHALL implement the FIFO as the sub-module convol_sync_fifo (push/pop/full/empty/level).
REQ-035 SHALL implement the rounding/saturation stage in the top level.
REQ-036 SHALL be connectable to a convol_result_intf slave modport.

Verification (DATA_SIZE=16, FULL_SIZE=40, SHIFT=8, DEPTH=8)
REQ-037 SHALL cover: output_data=384 valid one cycle, out_ready=1 -> out_data=2, out_valid high exactly 2 edges later for 1 cycle; output_data=-384 -> out_data=-1.
REQ-038 SHALL cover: output_data=2^30 -> out_data=32767, sat_flag=1, sat_count=1; output_data=-2^30 -> -32768, sat_count=2.
REQ-039 SHALL cover: out_ready=0, 10 consecutive valids (values 256*k, k=1..10) -> level=8, overflow=1, drop_count=2; then out_ready=1 -> pops 1..8 in order.
REQ-040 SHALL cover: FIFO full, out_ready=1 with continuous valids -> level stays 8, no drops, order preserved.
REQ-041 SHALL cover: reset pulsed low mid-burst with level=5 -> out_valid=0, level=0 asynchronously; next sample after release emerges alone 2 edges later.
REQ-042 SHALL cover: clear_flags asserted in the same cycle as a drop -> overflow=0, drop_count=0 after the edge; build without CONVOL_SHAPER_STATS_EN -> counters always 0.
